// File: rtl/pipe_stage_hs_pkg.sv
// Shared types for the handshaked pipeline stage.
//   ps_state_e   : occupancy state of a stage (EMPTY / ONE / TWO)
//   PS_STATE_W   : width of the state encoding
//   ps_occupancy : maps a state to its entry count (illegal encodings -> 0)
package pipe_stage_hs_pkg;

    localparam int unsigned PS_STATE_W = 2;

    typedef enum logic [PS_STATE_W-1:0] {
        PS_EMPTY = 2'b00,
        PS_ONE   = 2'b01,
        PS_TWO   = 2'b10
    } ps_state_e;

    function automatic logic [1:0] ps_occupancy(input ps_state_e s);
        case (s)
            PS_ONE:  return 2'd1;
            PS_TWO:  return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_hs_flopenrc.sv
// Register with asynchronous reset, synchronous clear and load enable.
//   clk   : clock, rising edge
//   reset : asynchronous, active-high; loads RESET_VAL
//   clear : synchronous clear to RESET_VAL, wins over en
//   en    : load d on the next rising edge
//   d / q : data in / registered data out
module flopenrc #(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (clear) begin
            q <= RESET_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// One pipeline stage with valid/ready handshake, synchronous flush and an
// optional second (skid) entry.
//   clk, reset          : clock (rising edge), asynchronous active-high reset
//   flush               : synchronous kill of every held entry
//   in_valid/in_ready   : upstream handshake, in_data is the payload
//   out_valid/out_ready : downstream handshake, out_data is the head payload
//   occupancy           : number of entries held (0..2)
// SKID=1 gives a registered in_ready (pure state decode); SKID=0 is a single
// entry whose in_ready looks through to out_ready combinationally.
module pipe_stage_hs
    import pipe_stage_hs_pkg::*;
#(
    parameter int unsigned       WIDTH     = 32,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0,
    parameter int unsigned       SKID      = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy
);

    ps_state_e        state_q;
    ps_state_e        state_d;
    logic             in_fire;
    logic             out_fire;
    logic             main_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic             skid_en;
    logic [WIDTH-1:0] skid_q;

    assign out_valid = (state_q != PS_EMPTY);
    assign out_data  = main_q;
    assign occupancy = ps_occupancy(state_q);

    if (SKID != 0) begin : g_ready_reg
        assign in_ready = (state_q != PS_TWO);
    end else begin : g_ready_comb
        assign in_ready = !out_valid || out_ready;
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= PS_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_en = 1'b0;
        main_d  = in_data;
        skid_en = 1'b0;
        case (state_q)
            PS_EMPTY: begin
                if (in_fire) begin
                    state_d = PS_ONE;
                    main_en = 1'b1;
                end
            end
            PS_ONE: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    // With SKID=0 in_fire in ONE implies out_fire, so this
                    // branch is only reachable with a skid entry present.
                    state_d = PS_TWO;
                    skid_en = 1'b1;
                end else if (out_fire) begin
                    state_d = PS_EMPTY;
                end
            end
            PS_TWO: begin
                if (out_fire) begin
                    state_d = PS_ONE;
                    main_en = 1'b1;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = PS_EMPTY;
            end
        endcase
        if (flush) begin
            state_d = PS_EMPTY;
        end
    end

    flopenrc #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .clear (flush),
        .d     (main_d),
        .q     (main_q)
    );

    if (SKID != 0) begin : g_skid
        flopenrc #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_skid (
            .clk   (clk),
            .reset (reset),
            .en    (skid_en),
            .clear (flush),
            .d     (in_data),
            .q     (skid_q)
        );
    end else begin : g_no_skid
        assign skid_q = RESET_VAL;
    end

endmodule

// File: tb/tb_pipe_stage_hs.sv
module tb_pipe_stage_hs;

    localparam logic [31:0] RV_A = 32'h0000_0000;
    localparam logic [31:0] RV_B = 32'hCAFE_F00D;

    logic clk = 1'b0;
    logic reset;

    logic        a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [31:0] a_in_data, a_out_data;
    logic [1:0]  a_occ;
    logic        b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [31:0] b_in_data, b_out_data;
    logic [1:0]  b_occ;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Reference model: each stage is an ordered FIFO of accepted payloads.
    logic [31:0] qa[$];
    logic [31:0] qb[$];

    always #5 clk = ~clk;

    pipe_stage_hs #(.WIDTH(32), .RESET_VAL(RV_A), .SKID(1)) u_dut_a (
        .clk(clk), .reset(reset), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_stage_hs #(.WIDTH(32), .RESET_VAL(RV_B), .SKID(0)) u_dut_b (
        .clk(clk), .reset(reset), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    task automatic idle_inputs();
        a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_data = '0;
        b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_data = '0;
    endtask

    // Advance one clock edge, updating both models from their own rules.
    task automatic step();
        bit a_inf, a_outf, b_inf, b_outf;
        a_inf  = a_in_valid && (qa.size() < 2);
        a_outf = a_out_ready && (qa.size() != 0);
        b_inf  = b_in_valid && (qb.size() == 0 || b_out_ready);
        b_outf = b_out_ready && (qb.size() != 0);
        @(posedge clk);
        if (a_flush) qa.delete();
        else begin
            if (a_outf) void'(qa.pop_front());
            if (a_inf)  qa.push_back(a_in_data);
        end
        if (b_flush) qb.delete();
        else begin
            if (b_outf) void'(qb.pop_front());
            if (b_inf)  qb.push_back(b_in_data);
        end
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        n_checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_occ !== 2'd0 || a_out_data !== RV_A) begin
            n_fail++; $display("FAIL reset_a: valid=%b ready=%b occ=%0d data=%h, want 0 1 0 %h", a_out_valid, a_in_ready, a_occ, a_out_data, RV_A);
        end
        n_checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_occ !== 2'd0 || b_out_data !== RV_B) begin
            n_fail++; $display("FAIL reset_b: valid=%b ready=%b occ=%0d data=%h, want 0 1 0 %h", b_out_valid, b_in_ready, b_occ, b_out_data, RV_B);
        end
        reset = 1'b0;
        step();
    endtask

    task automatic test_reset_midstream();
        a_out_ready = 0; a_in_valid = 1;
        a_in_data = 32'h11; step();
        a_in_data = 32'h22; step();
        a_in_valid = 0;
        n_checks++; if (a_occ !== 2'd2 || a_out_data !== 32'h11) begin
            n_fail++; $display("FAIL pre_reset_full: occ=%0d data=%h, want 2 00000011", a_occ, a_out_data);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (a_out_valid !== 1'b0 || a_out_data !== 32'h0 || a_in_ready !== 1'b1 || a_occ !== 2'd0) begin
            n_fail++; $display("FAIL async_reset: valid=%b data=%h ready=%b occ=%0d, want 0 0 1 0", a_out_valid, a_out_data, a_in_ready, a_occ);
        end
        #1 reset = 1'b0;
        qa.delete(); qb.delete();
        idle_inputs();
        step();
    endtask

    task automatic test_streaming();
        a_out_ready = 1; a_in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            a_in_data = 32'h8000_0000 + 32'(4 * i);
            #1;
            n_checks++; if (a_in_ready !== 1'b1) begin
                n_fail++; $display("FAIL stream_ready[%0d]: got %b want 1", i, a_in_ready);
            end
            step();
            n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 32'h8000_0000 + 32'(4 * i) || a_occ !== 2'd1) begin
                n_fail++; $display("FAIL stream_data[%0d]: valid=%b data=%h occ=%0d, want 1 %h 1", i, a_out_valid, a_out_data, a_occ, 32'h8000_0000 + 32'(4 * i));
            end
        end
        a_in_valid = 0; step();
        n_checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
            n_fail++; $display("FAIL stream_drain: valid=%b occ=%0d, want 0 0", a_out_valid, a_occ);
        end
        idle_inputs();
    endtask

    task automatic test_backpressure();
        a_out_ready = 0; a_in_valid = 1;
        a_in_data = 32'h11; step();
        a_in_data = 32'h22; step();
        a_in_valid = 0; a_in_data = 32'h99;
        n_checks++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0 || a_out_data !== 32'h11) begin
            n_fail++; $display("FAIL bp_full: occ=%0d ready=%b data=%h, want 2 0 00000011", a_occ, a_in_ready, a_out_data);
        end
        step();
        n_checks++; if (a_occ !== 2'd2 || a_out_data !== 32'h11) begin
            n_fail++; $display("FAIL bp_hold: occ=%0d data=%h, want 2 00000011", a_occ, a_out_data);
        end
        a_out_ready = 1; step();
        n_checks++; if (a_occ !== 2'd1 || a_out_data !== 32'h22 || a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_drain1: occ=%0d data=%h ready=%b, want 1 00000022 1", a_occ, a_out_data, a_in_ready);
        end
        step();
        n_checks++; if (a_occ !== 2'd0 || a_out_valid !== 1'b0 || a_out_data !== 32'h22) begin
            n_fail++; $display("FAIL bp_drain2: occ=%0d valid=%b data=%h, want 0 0 00000022", a_occ, a_out_valid, a_out_data);
        end
        idle_inputs();
    endtask

    task automatic test_simultaneous();
        int seen33 = 0;
        a_in_valid = 1; a_in_data = 32'h33; step();
        a_in_data = 32'h44; a_out_ready = 1;
        #1;
        if (a_out_valid && a_out_data == 32'h33) seen33++;
        step();
        a_in_valid = 0;
        n_checks++; if (a_occ !== 2'd1 || a_out_data !== 32'h44) begin
            n_fail++; $display("FAIL simul: occ=%0d data=%h, want 1 00000044", a_occ, a_out_data);
        end
        if (a_out_valid && a_out_data == 32'h33) seen33++;
        step();
        n_checks++; if (seen33 != 1 || a_occ !== 2'd0) begin
            n_fail++; $display("FAIL simul_once: 0x33 seen %0d times occ=%0d, want 1 0", seen33, a_occ);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        a_in_valid = 1;
        a_in_data = 32'h66; step();
        a_in_data = 32'h77; step();
        a_in_data = 32'h55; a_flush = 1;
        step();
        a_flush = 0; a_in_valid = 0; a_out_ready = 1;
        n_checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_data !== RV_A) begin
            n_fail++; $display("FAIL flush_two: valid=%b occ=%0d data=%h, want 0 0 %h", a_out_valid, a_occ, a_out_data, RV_A);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++; if (a_out_valid !== 1'b0) begin
                n_fail++; $display("FAIL flush_residue[%0d]: valid=%b data=%h, want 0", i, a_out_valid, a_out_data);
            end
        end
        // Flush in ONE with a simultaneous accept: the new word is discarded.
        a_out_ready = 0; a_in_valid = 1; a_in_data = 32'h88; step();
        a_in_data = 32'h89; a_flush = 1;
        #1;
        n_checks++; if (a_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL flush_ready: got %b want 1", a_in_ready);
        end
        step();
        a_flush = 0; a_in_valid = 0;
        n_checks++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0) begin
            n_fail++; $display("FAIL flush_one: valid=%b occ=%0d, want 0 0", a_out_valid, a_occ);
        end
        idle_inputs();
    endtask

    task automatic test_skid0();
        b_in_valid = 1; b_in_data = 32'hA1; b_out_ready = 0; step();
        b_in_data = 32'hA2;
        #1;
        n_checks++; if (b_in_ready !== 1'b0 || b_occ !== 2'd1 || b_out_data !== 32'hA1) begin
            n_fail++; $display("FAIL skid0_full: ready=%b occ=%0d data=%h, want 0 1 000000a1", b_in_ready, b_occ, b_out_data);
        end
        b_out_ready = 1;
        #1;
        n_checks++; if (b_in_ready !== 1'b1) begin
            n_fail++; $display("FAIL skid0_ready_comb: got %b want 1", b_in_ready);
        end
        for (int i = 0; i < 6; i++) begin
            step();
            n_checks++; if (b_out_data !== 32'hA2 + 32'(i) || b_occ !== 2'd1 || b_in_ready !== 1'b1) begin
                n_fail++; $display("FAIL skid0_stream[%0d]: data=%h occ=%0d ready=%b, want %h 1 1", i, b_out_data, b_occ, b_in_ready, 32'hA2 + 32'(i));
            end
            b_in_data = 32'hA3 + 32'(i);
        end
        b_in_valid = 0; b_flush = 1; step(); b_flush = 0;
        n_checks++; if (b_out_valid !== 1'b0 || b_out_data !== RV_B) begin
            n_fail++; $display("FAIL skid0_flush: valid=%b data=%h, want 0 %h", b_out_valid, b_out_data, RV_B);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        int unsigned bad = 0;
        for (int i = 0; i < 400; i++) begin
            a_in_valid  = ($urandom_range(0, 3) != 0);
            a_out_ready = ($urandom_range(0, 2) != 0);
            a_flush     = ($urandom_range(0, 19) == 0);
            a_in_data   = $urandom;
            b_in_valid  = ($urandom_range(0, 3) != 0);
            b_out_ready = ($urandom_range(0, 2) != 0);
            b_flush     = ($urandom_range(0, 19) == 0);
            b_in_data   = $urandom;
            #1;
            n_checks++;
            if (a_in_ready !== (qa.size() < 2) || a_out_valid !== (qa.size() != 0) ||
                a_occ !== 2'(qa.size()) || (qa.size() != 0 && a_out_data !== qa[0])) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL rand_a[%0d]: ready=%b valid=%b occ=%0d data=%h, model size %0d head %h",
                    i, a_in_ready, a_out_valid, a_occ, a_out_data, qa.size(), (qa.size() != 0) ? qa[0] : 32'h0);
            end
            n_checks++;
            if (b_in_ready !== (qb.size() == 0 || b_out_ready) || b_out_valid !== (qb.size() != 0) ||
                b_occ !== 2'(qb.size()) || (qb.size() != 0 && b_out_data !== qb[0])) begin
                n_fail++; bad++;
                if (bad < 10) $display("FAIL rand_b[%0d]: ready=%b valid=%b occ=%0d data=%h, model size %0d head %h",
                    i, b_in_ready, b_out_valid, b_occ, b_out_data, qb.size(), (qb.size() != 0) ? qb[0] : 32'h0);
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_reset_midstream();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_skid0();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
